// File: rtl/datapath_multicycle_pkg.sv
// Shared types for the multi-cycle datapath: phases, ALU selects and memory access widths.
package datapath_multicycle_pkg;

  localparam int unsigned ILEN = 32;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} phase_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_Y
  } alu_op_t;

  typedef enum logic {ALU_X_REG, ALU_X_PC} alu_x_t;
  typedef enum logic {ALU_Y_REG, ALU_Y_IMM} alu_y_t;

  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_DWORD} mem_width_t;

  // Number of significant bits returned by the memory for a given access width.
  function automatic int unsigned width_bits(mem_width_t w);
    case (w)
      MEM_BYTE: return 8;
      MEM_HALF: return 16;
      MEM_WORD: return 32;
      default:  return 64;
    endcase
  endfunction

endpackage

// File: rtl/datapath_multicycle_sequencer.sv
// Phase sequencer: walks FETCH..WRITEBACK, stalls on memory wait states, pulses retire.
module datapath_multicycle_sequencer
  import datapath_multicycle_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   mem_ready,
  input  logic   ctl_load,
  input  logic   ctl_store,
  output phase_t phase,
  output logic   mem_valid,
  output logic   retire
);

  phase_t phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (rst) phase_q <= FETCH;
    else     phase_q <= phase_d;
  end

  // Request/retire are gated by rst so an in-flight access is dropped the same cycle.
  always_comb begin
    phase_d   = phase_q;
    mem_valid = 1'b0;
    retire    = 1'b0;
    case (phase_q)
      FETCH: begin
        mem_valid = ~rst;
        if (mem_ready) phase_d = DECODE;
      end
      DECODE:  phase_d = EXECUTE;
      EXECUTE: phase_d = (ctl_load | ctl_store) ? MEMORY : WRITEBACK;
      MEMORY: begin
        mem_valid = ~rst;
        if (mem_ready) phase_d = WRITEBACK;
      end
      WRITEBACK: begin
        retire  = ~rst;
        phase_d = FETCH;
      end
      default: phase_d = FETCH;
    endcase
  end

  assign phase = phase_q;

endmodule

// File: rtl/datapath_multicycle.sv
// Multi-cycle datapath: architectural PC/IR/A/B/ALU_OUT/MDR state, regfile, ALU and load extension.
// Load data is expected right-justified on mem_data_rd; extension uses the low ctl_width bits.
module datapath_multicycle
  import datapath_multicycle_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      REG_COUNT = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [XLEN-1:0]              mem_addr,
  output mem_width_t                   mem_width,
  output logic [XLEN-1:0]              mem_data_wr,
  input  logic [XLEN-1:0]              mem_data_rd,
  output logic [ILEN-1:0]              instr,
  output logic [XLEN-1:0]              pc,
  output phase_t                       phase,
  output logic                         retire,
  input  logic [$clog2(REG_COUNT)-1:0] rs1,
  input  logic [$clog2(REG_COUNT)-1:0] rs2,
  input  logic [$clog2(REG_COUNT)-1:0] rd,
  input  logic [XLEN-1:0]              immed,
  input  alu_op_t                      alu_op,
  input  alu_x_t                       alu_x_sel,
  input  alu_y_t                       alu_y_sel,
  input  logic                         ctl_load,
  input  logic                         ctl_store,
  input  mem_width_t                   ctl_width,
  input  logic                         ctl_signed,
  input  logic                         ctl_rd_we,
  input  logic                         ctl_link,
  input  logic                         ctl_pc_alu
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [ILEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] rf_q [REG_COUNT];

  logic [XLEN-1:0] rs1_val, rs2_val, alu_x, alu_y, alu_res, pc_plus4;
  logic [XLEN-1:0] ld_shl, ld_ext, rf_wdata;
  logic signed [XLEN-1:0] ld_sx;
  logic [SHW-1:0]  shamt;
  logic            rf_we, is_load;
  int unsigned     ld_bits, ld_sh;

  datapath_multicycle_sequencer u_seq (
    .clk       (clk),
    .rst       (rst),
    .mem_ready (mem_ready),
    .ctl_load  (ctl_load),
    .ctl_store (ctl_store),
    .phase     (phase),
    .mem_valid (mem_valid),
    .retire    (retire)
  );

  // Load and store together behave as a store.
  assign is_load  = ctl_load & ~ctl_store;
  assign rs1_val  = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_val  = (rs2 == '0) ? '0 : rf_q[rs2];
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    alu_x   = (alu_x_sel == ALU_X_PC)  ? pc_q  : a_q;
    alu_y   = (alu_y_sel == ALU_Y_IMM) ? immed : b_q;
    shamt   = alu_y[SHW-1:0];
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = alu_x + alu_y;
      ALU_SUB:    alu_res = alu_x - alu_y;
      ALU_AND:    alu_res = alu_x & alu_y;
      ALU_OR:     alu_res = alu_x | alu_y;
      ALU_XOR:    alu_res = alu_x ^ alu_y;
      ALU_SLL:    alu_res = alu_x << shamt;
      ALU_SRL:    alu_res = alu_x >> shamt;
      ALU_SRA:    alu_res = $signed(alu_x) >>> shamt;
      ALU_SLT:    alu_res = XLEN'($signed(alu_x) < $signed(alu_y));
      ALU_SLTU:   alu_res = XLEN'(alu_x < alu_y);
      ALU_PASS_Y: alu_res = alu_y;
      default:    alu_res = '0;
    endcase
  end

  // Extension by shifting the field to the top and back; covers full-width accesses too.
  always_comb begin
    ld_bits = width_bits(ctl_width);
    ld_sh   = (ld_bits >= XLEN) ? 0 : XLEN - ld_bits;
    ld_shl  = mem_data_rd << ld_sh;
    ld_sx   = $signed(ld_shl) >>> ld_sh;
    if (ctl_signed) ld_ext = ld_sx;
    else            ld_ext = ld_shl >> ld_sh;
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_out_q;
    case (phase)
      FETCH:   if (mem_ready) ir_d = mem_data_rd[ILEN-1:0];
      DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
      end
      EXECUTE: alu_out_d = alu_res;
      MEMORY:  if (mem_ready && is_load) mdr_d = ld_ext;
      WRITEBACK: begin
        rf_we    = ctl_rd_we && (rd != '0);
        rf_wdata = ctl_link ? pc_plus4 : (is_load ? mdr_q : alu_out_q);
        pc_d     = ctl_pc_alu ? alu_out_q : pc_plus4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end

  // Register file contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && rf_we) rf_q[rd] <= rf_wdata;
  end

  assign mem_addr    = (phase == FETCH) ? pc_q : alu_out_q;
  assign mem_we      = mem_valid && (phase == MEMORY) && ctl_store;
  assign mem_width   = (phase == FETCH) ? MEM_WORD : ctl_width;
  assign mem_data_wr = b_q;
  assign instr       = ir_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_datapath_multicycle.sv
// Directed bench for datapath_multicycle with a transaction-level reference model and per-cycle compare.
module tb_datapath_multicycle;
  import datapath_multicycle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_valid, mem_ready, mem_we, retire;
  logic [31:0] mem_addr, mem_data_wr, mem_data_rd, instr, pc, immed;
  mem_width_t mem_width, ctl_width;
  phase_t phase;
  logic [4:0] rs1, rs2, rd;
  alu_op_t alu_op;
  alu_x_t alu_x_sel;
  alu_y_t alu_y_sel;
  logic ctl_load, ctl_store, ctl_signed, ctl_rd_we, ctl_link, ctl_pc_alu;

  int total = 0;
  int bad = 0;

  datapath_multicycle #(.XLEN(32), .REG_COUNT(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_width(mem_width), .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
    .instr(instr), .pc(pc), .phase(phase), .retire(retire), .rs1(rs1), .rs2(rs2), .rd(rd),
    .immed(immed), .alu_op(alu_op), .alu_x_sel(alu_x_sel), .alu_y_sel(alu_y_sel),
    .ctl_load(ctl_load), .ctl_store(ctl_store), .ctl_width(ctl_width), .ctl_signed(ctl_signed),
    .ctl_rd_we(ctl_rd_we), .ctl_link(ctl_link), .ctl_pc_alu(ctl_pc_alu)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    alu_op_t op;
    alu_x_t xs;
    alu_y_t ys;
    logic ld, st;
    mem_width_t w;
    logic sg, we, lk, pa;
    int fw, mw;
    logic [31:0] rdata;
  } ins_t;

  typedef struct {
    phase_t ph;
    logic ready;
    logic [31:0] rdata;
    logic valid;
    logic [31:0] addr;
    logic we;
    mem_width_t w;
    logic chk_wr;
    logic [31:0] wr;
    logic chk_ir;
    logic [31:0] ir;
  } cyc_t;

  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  cyc_t exp_c;
  logic [31:0] exp_pc;
  logic chk_en = 1'b0;
  int n_ins = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] m_alu(alu_op_t op, logic [31:0] x, logic [31:0] y);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_SLL:  r = x << y[4:0];
      ALU_SRL:  r = x >> y[4:0];
      ALU_SRA:  r = $signed(x) >>> y[4:0];
      ALU_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      default:  r = y;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] m_ext(logic [31:0] d, mem_width_t w, logic sg);
    case (w)
      MEM_BYTE: return sg ? {{24{d[7]}}, d[7:0]} : {24'h0, d[7:0]};
      MEM_HALF: return sg ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
      default:  return d;
    endcase
  endfunction

  function automatic ins_t base();
    ins_t t;
    t.rs1 = 0; t.rs2 = 0; t.rd = 0; t.imm = 0; t.op = ALU_ADD; t.xs = ALU_X_REG; t.ys = ALU_Y_IMM;
    t.ld = 0; t.st = 0; t.w = MEM_WORD; t.sg = 0; t.we = 0; t.lk = 0; t.pa = 0;
    t.fw = 0; t.mw = 0; t.rdata = 0;
    return t;
  endfunction

  function automatic ins_t opi(alu_op_t op, logic [4:0] d, logic [4:0] s1, logic [31:0] imm);
    ins_t t = base();
    t.op = op; t.rd = d; t.rs1 = s1; t.imm = imm; t.we = 1;
    return t;
  endfunction

  function automatic ins_t opr(alu_op_t op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
    ins_t t = opi(op, d, s1, 32'h0);
    t.rs2 = s2; t.ys = ALU_Y_REG;
    return t;
  endfunction

  function automatic ins_t ldi(logic [4:0] d, logic [31:0] a, mem_width_t w, logic sg,
                               logic [31:0] data, int mw);
    ins_t t = opi(ALU_ADD, d, 5'd0, a);
    t.ld = 1; t.w = w; t.sg = sg; t.rdata = data; t.mw = mw;
    return t;
  endfunction

  function automatic ins_t sti(logic [4:0] s2, logic [31:0] a, mem_width_t w, int mw);
    ins_t t = base();
    t.rs2 = s2; t.imm = a; t.st = 1; t.w = w; t.mw = mw;
    return t;
  endfunction

  function automatic ins_t jmp(logic [4:0] d, alu_x_t xs, logic [31:0] imm, logic link);
    ins_t t = base();
    t.rd = d; t.xs = xs; t.imm = imm; t.lk = link; t.we = link; t.pa = 1;
    return t;
  endfunction

  function automatic cyc_t cyc(phase_t ph, logic ready, logic [31:0] rdata, logic [31:0] ir);
    cyc_t c;
    c.ph = ph; c.ready = ready; c.rdata = rdata; c.valid = 0; c.addr = 0; c.we = 0;
    c.w = MEM_WORD; c.chk_wr = 0; c.wr = 0; c.chk_ir = 1; c.ir = ir;
    return c;
  endfunction

  task automatic set_ctl(input ins_t t);
    rs1 = t.rs1; rs2 = t.rs2; rd = t.rd; immed = t.imm; alu_op = t.op;
    alu_x_sel = t.xs; alu_y_sel = t.ys; ctl_load = t.ld; ctl_store = t.st; ctl_width = t.w;
    ctl_signed = t.sg; ctl_rd_we = t.we; ctl_link = t.lk; ctl_pc_alu = t.pa;
  endtask

  // Expected cycle trace and architectural effect of one instruction; drives the memory side.
  task automatic exec(input ins_t t, output int lat, output logic [31:0] wr);
    cyc_t q[$];
    cyc_t c;
    logic [31:0] a, b, x, y, res, wb, fword;
    logic is_ld;
    fword = 32'hC0DE_0000 | 32'(n_ins);
    n_ins++;
    a = (t.rs1 == 0) ? 32'h0 : m_rf[t.rs1];
    b = (t.rs2 == 0) ? 32'h0 : m_rf[t.rs2];
    x = (t.xs == ALU_X_PC) ? m_pc : a;
    y = (t.ys == ALU_Y_IMM) ? t.imm : b;
    res = m_alu(t.op, x, y);
    is_ld = t.ld && !t.st;
    wb = t.lk ? m_pc + 32'd4 : (is_ld ? m_ext(t.rdata, t.w, t.sg) : res);
    set_ctl(t);
    for (int i = 0; i <= t.fw; i++) begin
      c = cyc(FETCH, i == t.fw, (i == t.fw) ? fword : 32'hBAD0_0000 | 32'(i), fword);
      c.valid = 1; c.addr = m_pc; c.chk_ir = 0;
      q.push_back(c);
    end
    q.push_back(cyc(DECODE, 1'b1, 32'hBAD1_0000, fword));
    q.push_back(cyc(EXECUTE, 1'b1, 32'hBAD2_0000, fword));
    if (t.ld || t.st) begin
      for (int i = 0; i <= t.mw; i++) begin
        c = cyc(MEMORY, i == t.mw, (i == t.mw) ? t.rdata : 32'hBAD3_0000 | 32'(i), fword);
        c.valid = 1; c.addr = res; c.we = t.st; c.w = t.w; c.chk_wr = t.st; c.wr = b;
        q.push_back(c);
      end
    end
    q.push_back(cyc(WRITEBACK, 1'b1, 32'hBAD4_0000, fword));
    exp_pc = m_pc;
    lat = 0;
    wr = 32'h0;
    foreach (q[i]) begin
      mem_ready = q[i].ready;
      mem_data_rd = q[i].rdata;
      exp_c = q[i];
      chk_en = 1'b1;
      @(negedge clk);
      if (retire && lat == 0) lat = i + 1;
      if (mem_valid && mem_we) wr = mem_data_wr;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    if (t.we && t.rd != 0) m_rf[t.rd] = wb;
    m_pc = t.pa ? res : m_pc + 32'd4;
  endtask

  // Per-cycle compare against the expected trace.
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", 64'(phase), 64'(exp_c.ph));
      check("mem_valid", 64'(mem_valid), 64'(exp_c.valid));
      check("retire", 64'(retire), 64'(exp_c.ph == WRITEBACK));
      check("pc", 64'(pc), 64'(exp_pc));
      if (exp_c.valid) begin
        check("mem_addr", 64'(mem_addr), 64'(exp_c.addr));
        check("mem_we", 64'(mem_we), 64'(exp_c.we));
        check("mem_width", 64'(mem_width), 64'(exp_c.w));
      end
      if (exp_c.chk_wr) check("mem_data_wr", 64'(mem_data_wr), 64'(exp_c.wr));
      if (exp_c.chk_ir) check("instr", 64'(instr), 64'(exp_c.ir));
    end
  end

  task automatic rd_reg(input logic [4:0] r, input logic [31:0] want, input string nm);
    int lat;
    logic [31:0] wr;
    exec(sti(r, 32'h300, MEM_WORD, 0), lat, wr);
    check(nm, 64'(wr), 64'(want));
  endtask

  initial begin
    int lat;
    logic [31:0] wr;
    ins_t t;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    set_ctl(base());
    mem_data_rd = 32'h0;
    mem_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_retire", 64'(retire), 64'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("reset_pc", 64'(pc), 64'h100);
    check("reset_phase", 64'(phase), 64'(FETCH));
    check("reset_mem_valid", 64'(mem_valid), 64'd1);
    check("reset_mem_addr", 64'(mem_addr), 64'h100);
    check("reset_instr", 64'(instr), 64'd0);
    m_pc = 32'h100;

    exec(opi(ALU_ADD, 5'd1, 5'd0, 32'd5), lat, wr);
    exec(opi(ALU_ADD, 5'd2, 5'd0, 32'd7), lat, wr);
    exec(opr(ALU_ADD, 5'd3, 5'd1, 5'd2), lat, wr);
    check("add_latency", 64'(lat), 64'd4);
    check("add_pc_next", 64'(pc), 64'h10C);
    rd_reg(5'd3, 32'd12, "add_r3");

    exec(ldi(5'd4, 32'h200, MEM_BYTE, 1'b1, 32'h80, 3), lat, wr);
    check("lb_latency", 64'(lat), 64'd8);
    rd_reg(5'd4, 32'hFFFF_FF80, "lb_signed_r4");

    t = ldi(5'd5, 32'h202, MEM_HALF, 1'b0, 32'h1234_8765, 0);
    t.fw = 2;
    exec(t, lat, wr);
    check("lhu_latency", 64'(lat), 64'd7);
    rd_reg(5'd5, 32'h0000_8765, "lhu_r5");

    exec(ldi(5'd6, 32'h204, MEM_WORD, 1'b0, 32'hDEAD_BEEF, 0), lat, wr);
    exec(sti(5'd6, 32'h304, MEM_WORD, 1), lat, wr);
    check("sw_latency", 64'(lat), 64'd6);
    check("sw_data", 64'(wr), 64'hDEAD_BEEF);

    exec(ldi(5'd7, 32'h201, MEM_BYTE, 1'b1, 32'hFFFF_FF7F, 0), lat, wr);
    rd_reg(5'd7, 32'h0000_007F, "lb_pos_r7");

    exec(opr(ALU_SUB, 5'd8, 5'd1, 5'd2), lat, wr);
    exec(opr(ALU_SLT, 5'd9, 5'd8, 5'd1), lat, wr);
    exec(opr(ALU_SLTU, 5'd10, 5'd8, 5'd1), lat, wr);
    exec(opi(ALU_SRA, 5'd11, 5'd4, 32'd4), lat, wr);
    exec(opr(ALU_XOR, 5'd12, 5'd6, 5'd3), lat, wr);
    rd_reg(5'd8, 32'hFFFF_FFFE, "sub_r8");
    rd_reg(5'd9, 32'd1, "slt_r9");
    rd_reg(5'd10, 32'd0, "sltu_r10");
    rd_reg(5'd11, 32'hFFFF_FFF8, "sra_r11");
    rd_reg(5'd12, 32'hDEAD_BEE3, "xor_r12");

    t = ldi(5'd13, 32'h280, MEM_WORD, 1'b0, 32'h1111_1111, 0);
    t.st = 1'b1;
    exec(t, lat, wr);
    rd_reg(5'd13, 32'h280, "ldst_r13_gets_alu");

    exec(jmp(5'd0, ALU_X_REG, 32'h40, 1'b0), lat, wr);
    check("jump_pc", 64'(pc), 64'h40);
    exec(jmp(5'd14, ALU_X_PC, 32'h40, 1'b1), lat, wr);
    check("jal_pc", 64'(pc), 64'h80);
    check("jal_fetch_addr", 64'(mem_addr), 64'h80);
    rd_reg(5'd14, 32'h44, "jal_link_r14");
    t = jmp(5'd0, ALU_X_PC, 32'h8, 1'b1);
    t.we = 1'b1;
    exec(t, lat, wr);
    rd_reg(5'd0, 32'h0, "r0_stays_zero");

    exec(jmp(5'd0, ALU_X_REG, 32'hFFFF_FFFC, 1'b0), lat, wr);
    check("top_pc", 64'(pc), 64'hFFFF_FFFC);
    exec(opi(ALU_ADD, 5'd0, 5'd0, 32'd0), lat, wr);
    check("pc_wrap", 64'(pc), 64'h0);

    // Reset abandons a load stuck in MEMORY; no regfile write happens.
    set_ctl(ldi(5'd1, 32'h240, MEM_WORD, 1'b0, 32'h5555_AAAA, 0));
    mem_ready = 1'b1;
    mem_data_rd = 32'hC0DE_FFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_data_rd = 32'h5555_AAAA;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_pre_valid", 64'(mem_valid), 64'd1);
    check("abort_pre_addr", 64'(mem_addr), 64'h240);
    rst = 1'b1;
    #1;
    check("abort_valid_drop", 64'(mem_valid), 64'd0);
    @(posedge clk); #1;
    check("abort_valid_next", 64'(mem_valid), 64'd0);
    check("abort_phase", 64'(phase), 64'(FETCH));
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("abort_refetch_pc", 64'(pc), 64'h100);
    check("abort_refetch_addr", 64'(mem_addr), 64'h100);
    m_pc = 32'h100;
    rd_reg(5'd1, 32'd5, "abort_r1_unchanged");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
